// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: power-up wait, fixed init sequence, then round-robin
// arbitration of two byte-write requesters onto an HD44780-style LCD bus.
// Each byte is driven as SETUP -> E high -> HOLD -> settle WAIT.
module lcd_bus_scheduler #(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EH    = 25,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic [7:0] data_lcd,
    output logic       init_done,
    output logic       busy
);

    localparam int unsigned M_A   = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int unsigned M_B   = (T_CMD > T_EH) ? T_CMD : T_EH;
    localparam int unsigned M_C   = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int unsigned M_AB  = (M_A > M_B) ? M_A : M_B;
    localparam int unsigned T_MAX = (M_AB > M_C) ? M_AB : M_C;
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    init_idx;
    logic          locked;
    logic          owner;
    logic          ptr;
    logic          gnt0;
    logic          gnt1;
    logic          is_clr;
    logic [CW-1:0] wait_last;

    // Fixed power-on command sequence: function set, display on, entry mode, clear
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h0C;
            3'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction

    assign lcd_rw = 1'b0;

    // Clear/home commands need the long settle time
    assign is_clr    = !lcd_rs && (data_lcd == 8'h01 || data_lcd == 8'h02 || data_lcd == 8'h03);
    assign wait_last = is_clr ? CW'(T_CLR - 1) : CW'(T_CMD - 1);

    // Grant decision: lock owner first, otherwise round-robin pointer
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == S_IDLE && init_done) begin
            if (locked) begin
                gnt0 = !owner && req0_valid;
                gnt1 = owner && req1_valid;
            end else if (!ptr) begin
                gnt0 = req0_valid;
                gnt1 = !req0_valid && req1_valid;
            end else begin
                gnt1 = req1_valid;
                gnt0 = !req1_valid && req0_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Sequencer FSM with registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_PWRUP;
            cnt       <= '0;
            init_idx  <= 3'd0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            data_lcd  <= 8'h00;
            lcd_on    <= 1'b0;
            lcd_blon  <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b1;
            locked    <= 1'b0;
            owner     <= 1'b0;
            ptr       <= 1'b0;
        end else begin
            lcd_on   <= 1'b1;
            lcd_blon <= 1'b1;
            busy     <= 1'b1;
            case (state)
                S_PWRUP: begin
                    if (cnt == CW'(T_PWRUP - 1)) begin
                        cnt   <= '0;
                        state <= S_INIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_INIT: begin
                    data_lcd <= init_byte(init_idx);
                    lcd_rs   <= 1'b0;
                    init_idx <= init_idx + 3'd1;
                    cnt      <= '0;
                    state    <= S_SETUP;
                end
                S_SETUP: begin
                    if (cnt == CW'(T_SETUP - 1)) begin
                        cnt   <= '0;
                        lcd_e <= 1'b1;
                        state <= S_EHIGH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_EHIGH: begin
                    if (cnt == CW'(T_EH - 1)) begin
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == CW'(T_HOLD - 1)) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (!init_done && init_idx != 3'd4) begin
                            state <= S_INIT;
                        end else begin
                            state     <= S_IDLE;
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    busy <= 1'b0;
                    if (gnt0 || gnt1) begin
                        data_lcd <= gnt1 ? req1_data : req0_data;
                        lcd_rs   <= gnt1 ? req1_rs : req0_rs;
                        locked   <= gnt1 ? !req1_last : !req0_last;
                        owner    <= gnt1;
                        ptr      <= gnt0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= S_SETUP;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Randomized bench for lcd_bus_scheduler against a timeline-based reference model.
module tb_lcd_bus_scheduler;

    localparam int unsigned TP = 10;
    localparam int unsigned TS = 2;
    localparam int unsigned TE = 4;
    localparam int unsigned TH = 2;
    localparam int unsigned TC = 6;
    localparam int unsigned TL = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_rs, req0_last, req0_ready;
    logic       req1_valid, req1_rs, req1_last, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon, init_done, busy;
    logic [7:0] data_lcd;

    int checks = 0;
    int failures = 0;

    // Reference model: all timing kept as absolute cycle numbers
    int         cyc;
    int         next_ev;
    int         e_lo, e_hi;
    int         init_k;
    logic [7:0] m_data;
    logic       m_rs, m_done, ptr, locked, owner;
    logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    // Requester-side pending bytes
    logic [1:0] have;
    logic [7:0] bd [2];
    logic [1:0] brs, blast;

    lcd_bus_scheduler #(
        .T_PWRUP(TP), .T_SETUP(TS), .T_EH(TE), .T_HOLD(TH), .T_CMD(TC), .T_CLR(TL)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
        .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
        .req1_last(req1_last), .req1_ready(req1_ready),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_on(lcd_on),
        .lcd_blon(lcd_blon), .data_lcd(data_lcd), .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        next_ev = int'(TP);
        e_lo    = 1 << 30;
        e_hi    = -1;
        init_k  = 0;
        m_data  = 8'h00;
        m_rs    = 1'b0;
        m_done  = 1'b0;
        ptr     = 1'b0;
        locked  = 1'b0;
        owner   = 1'b0;
    endtask

    // A byte captured at cycle c: E window and next free cycle
    task automatic start_byte(input int c, input logic [7:0] dv, input logic rv);
        int w;
        w       = (!rv && dv >= 8'h01 && dv <= 8'h03) ? int'(TL) : int'(TC);
        e_lo    = c + 1 + int'(TS);
        e_hi    = c + int'(TS) + int'(TE);
        next_ev = c + 1 + int'(TS + TE + TH) + w;
        m_data  = dv;
        m_rs    = rv;
    endtask

    function automatic logic [7:0] pick_data();
        logic [7:0] v;
        case ($urandom_range(0, 5))
            0: v = 8'h01;
            1: v = 8'h02;
            2: v = 8'h03;
            3: v = 8'h41;
            4: v = 8'hC0;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    task automatic drive_ports();
        req0_valid = have[0]; req0_rs = brs[0]; req0_data = bd[0]; req0_last = blast[0];
        req1_valid = have[1]; req1_rs = brs[1]; req1_data = bd[1]; req1_last = blast[1];
    endtask

    // One cycle: present stimulus, compare at negedge, advance model, move past posedge
    task automatic step(input int pvalid);
        logic idle, g0, g1, r;
        for (int i = 0; i < 2; i++) begin
            if (!have[i] && $urandom_range(0, 99) < pvalid) begin
                have[i]  = 1'b1;
                bd[i]    = pick_data();
                brs[i]   = 1'($urandom_range(0, 1));
                blast[i] = ($urandom_range(0, 9) >= 3);
            end
        end
        drive_ports();
        @(negedge clk);
        if (!m_done && init_k == 4 && cyc >= next_ev) m_done = 1'b1;
        idle = m_done && cyc >= next_ev;
        g0 = 1'b0;
        g1 = 1'b0;
        if (idle) begin
            if (locked) begin
                g0 = !owner && have[0];
                g1 = owner && have[1];
            end else begin
                g0 = have[0] && (!ptr || !have[1]);
                g1 = have[1] && (ptr || !have[0]);
            end
        end
        check_eq("ready0", 32'(req0_ready), 32'(g0));
        check_eq("ready1", 32'(req1_ready), 32'(g1));
        check_eq("lcd_e", 32'(lcd_e), 32'(cyc >= e_lo && cyc <= e_hi));
        check_eq("data_lcd", 32'(data_lcd), 32'(m_data));
        check_eq("lcd_rs", 32'(lcd_rs), 32'(m_rs));
        check_eq("busy", 32'(busy), 32'(!idle));
        check_eq("init_done", 32'(init_done), 32'(m_done));
        check_eq("lcd_on", 32'(lcd_on), 32'(cyc >= 1));
        check_eq("lcd_blon", 32'(lcd_blon), 32'(cyc >= 1));
        check_eq("lcd_rw", 32'(lcd_rw), 32'd0);
        if (!m_done && init_k < 4 && cyc == next_ev) begin
            start_byte(cyc, init_seq[init_k], 1'b0);
            init_k++;
        end
        if (g0 || g1) begin
            r = g1;
            start_byte(cyc, bd[r], brs[r]);
            ptr     = !r;
            locked  = !blast[r];
            owner   = r;
            have[r] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_e"}, 32'(lcd_e), 32'd0);
        check_eq({tag, "_rs"}, 32'(lcd_rs), 32'd0);
        check_eq({tag, "_data"}, 32'(data_lcd), 32'd0);
        check_eq({tag, "_rw"}, 32'(lcd_rw), 32'd0);
        check_eq({tag, "_on"}, 32'(lcd_on), 32'd0);
        check_eq({tag, "_blon"}, 32'(lcd_blon), 32'd0);
        check_eq({tag, "_init_done"}, 32'(init_done), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_ready0"}, 32'(req0_ready), 32'd0);
        check_eq({tag, "_ready1"}, 32'(req1_ready), 32'd0);
    endtask

    initial begin
        int n;
        cyc   = 0;
        rst   = 1'b1;
        have  = 2'b11;
        bd[0] = 8'h41; bd[1] = 8'h42;
        brs   = 2'b11;
        blast = 2'b11;
        drive_ports();
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Both requesters nearly always valid: strict alternation and locked bursts
        repeat (1500) step(100);
        // Sparse, bursty requests
        repeat (1500) step(35);

        // Hit a cycle where E is high, then reset asynchronously mid-pulse
        n = 0;
        while (!(cyc >= e_lo && cyc <= e_hi) && n < 200) begin
            step(60);
            n++;
        end
        check_eq("ehigh_reached", 32'(cyc >= e_lo && cyc <= e_hi), 32'd1);
        #2;
        check_eq("pre_rst_e", 32'(lcd_e), 32'(cyc >= e_lo && cyc <= e_hi));
        check_eq("pre_rst_init_done", 32'(init_done), 32'(m_done));
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Init replays; lock and pointer must start fresh
        repeat (800) step(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Sequencer and arbiter for the 8-bit HD44780-style character LCD bus. Runs the power-up wait and the fixed init command sequence, then shares the bus between two byte-write requesters. Each accepted byte becomes one correctly timed E pulse, followed by the settle time that byte's command needs. It sits between the line-formatting logic (operand and result display writers) and the LCD pins.

## Interface
- T_PWRUP, 750000: cycles to wait after reset before the first init byte (15 ms at 50 MHz).
- T_SETUP, 2: cycles RS/data are stable with E low before E rises.
- T_EH, 25: cycles E is held high.
- T_HOLD, 2: cycles RS/data are held after E falls.
- T_CMD, 2000: settle cycles after a normal byte.
- T_CLR, 82000: settle cycles after a clear or home command.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req0_valid, req1_valid  in  1  the requester has a byte to write.
- req0_rs, req1_rs  in  1  0 = command, 1 = character data.
- req0_data, req1_data  in  8  byte to write.
- req0_last, req1_last  in  1  1 = this byte ends the requester's burst.
- req0_ready, req1_ready  out  1  the byte is accepted this cycle.
- lcd_e  out  1  enable strobe.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  read/write; tied to 0 (write only).
- lcd_on, lcd_blon  out  1  panel power and backlight.
- data_lcd  out  8  LCD data bus.
- init_done  out  1  init sequence is complete.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - PWRUP → INIT → SETUP → EHIGH → HOLD → WAIT.
  - WAIT returns to INIT while init bytes remain, otherwise to IDLE.
  - IDLE → SETUP on accept.
- PWRUP: counts T_PWRUP cycles with lcd_e=0.
- INIT: loads the next byte of the fixed sequence 0x38, 0x0C, 0x06, 0x01, all with rs=0. No requester is involved.
- After the 4th byte's WAIT: init_done goes to 1 and stays 1 until reset.
- IDLE and arbitration:
  - Requests are considered only when init_done=1.
  - Round-robin over the two requesters; after reset the pointer favours req0.
  - After each grant, the pointer favours the other requester.
- Accept: in IDLE, the granted requester with valid=1 sees ready=1 for exactly that cycle.
  - rs/data are captured into data_lcd/lcd_rs in that cycle.
  - Valid must not depend on ready.
  - The other requester's ready is 0.
- Lock: accepting a byte with last=0 locks the grant to that requester.
  - While locked, only that requester is considered, regardless of the pointer.
  - The lock clears when a byte with last=1 is accepted.
  - No timeout; the other requester waits indefinitely.
- SETUP lasts T_SETUP cycles, EHIGH lasts T_EH cycles (lcd_e=1), HOLD lasts T_HOLD cycles.
- WAIT lasts T_CLR cycles if rs=0 and data is 0x01, 0x02 or 0x03; otherwise T_CMD cycles.
- data_lcd and lcd_rs hold the last written value from capture until the next capture.
- Counter widths are sized with $clog2 of the largest parameter. Each parameter must be ≥1.
- Reset values:
  - lcd_e=0, lcd_rs=0, data_lcd=0x00, lcd_rw=0.
  - lcd_on=0, lcd_blon=0; both go to 1 on the first clock edge after rst falls.
  - init_done=0, busy=1, ready=0.
  - State PWRUP, lock cleared, pointer set to req0.
- Reset mid-operation (including during EHIGH): all outputs return to their reset values asynchronously. Any in-flight byte is dropped; a requester must re-present it. The full power-up and init sequence replays.

## Timing
- Capture is cycle 0. lcd_e rises at cycle 1+T_SETUP and falls at cycle 1+T_SETUP+T_EH.
- Earliest next accept: cycle 1+T_SETUP+T_EH+T_HOLD+T_wait, where T_wait is T_CMD or T_CLR.
- Each init byte follows the same SETUP/EHIGH/HOLD/WAIT timing. Its SETUP starts the cycle after INIT.
- busy is 0 only in IDLE; ready can be 1 only in IDLE.
- Simultaneous valid from both requesters with no lock: exactly one is granted, per the pointer.

## Test plan
Params for all scenarios: T_PWRUP=10, T_SETUP=2, T_EH=4, T_HOLD=2, T_CMD=6, T_CLR=20.
- Release rst → after 10 cycles, four E pulses with rs=0, data 38, 0C, 06, 01, each E high exactly 4 cycles. Gaps use 6 cycles of settle for the first three bytes and 20 after 01. init_done rises after the final WAIT; lcd_on/lcd_blon read 1 from the first edge.
- req0 writes rs=1, 0x41, last=1 → req0_ready pulses 1 cycle; lcd_e high during cycles 3–6; req0 held valid is re-accepted at cycle 15, not earlier.
- Both requesters continuously valid with last=1 → grant order 0, 1, 0, 1; each ready is a single-cycle pulse.
- req1 burst C0/rs=0, 47, 43 (last on 43) while req0 is valid → req1's three bytes are accepted back-to-back, then req0; 0xC0 uses a 6-cycle WAIT.
- req0 writes rs=0, 0x01 → WAIT is 20 cycles; rs=1, 0x01 → WAIT is 6 cycles.
- Assert rst while lcd_e=1 → lcd_e, init_done and data_lcd go to 0 before the next edge. After release the init sequence replays and the lock and pointer are reset.
